// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared encodings and types for the reduced RISC-V pipeline.
//   F3_*       : load/store size and sign selects carried in Funct3
//   RES_*      : writeback result-source selects
//   ex_mem_t   : control half of the EX/MEM pipeline register. The data half
//                is sized by each stage's WIDTH parameter, so it lives next to
//                the stage rather than in this package.
//   size_e / access_size : access width decoded from Funct3. Codes that are
//                not a byte or halfword access are treated as a word access.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] funct3;
        logic [4:0] rd;
    } ex_mem_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Execute-to-Memory bundle plus the Memory-stage results.
//   *E signals : produced by Execute, captured into EX/MEM
//   *M signals : EX/MEM register contents and load/misalign results
// Modports:
//   master : the Execute side (drives *E, observes *M)
//   slave  : the Memory stage (consumes *E, drives *M)
// -----------------------------------------------------------------------------
interface memory_stage_if #(
    parameter int WIDTH = 32
);
    logic             RegWriteE;
    logic [1:0]       ResultSrcE;
    logic             MemWriteE;
    logic [2:0]       Funct3E;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] WriteDataE;
    logic [4:0]       RdE;
    logic [WIDTH-1:0] PCPlus4E;

    logic             RegWriteM;
    logic [1:0]       ResultSrcM;
    logic [4:0]       RdM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] PCPlus4M;
    logic [WIDTH-1:0] ReadDataM;
    logic             MisalignM;

    modport master (
        output RegWriteE, ResultSrcE, MemWriteE, Funct3E,
               ALUResultE, WriteDataE, RdE, PCPlus4E,
        input  RegWriteM, ResultSrcM, RdM, ALUResultM,
               PCPlus4M, ReadDataM, MisalignM
    );

    modport slave (
        input  RegWriteE, ResultSrcE, MemWriteE, Funct3E,
               ALUResultE, WriteDataE, RdE, PCPlus4E,
        output RegWriteM, ResultSrcM, RdM, ALUResultM,
               PCPlus4M, ReadDataM, MisalignM
    );
endinterface

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-organised data RAM with per-byte write enables and an asynchronous
// read port, so a load issued right after a store to the same word observes
// the stored data in the same cycle. Contents are not reset.
//   clk   : write clock
//   we    : write strobe (already qualified by the caller)
//   be    : byte-lane enables, one per 8 bits of WIDTH
//   addr  : word index
//   wdata : write data, already placed on the enabled lanes
//   rdata : combinational read of the word at addr
// -----------------------------------------------------------------------------
module data_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WIDTH/8-1:0]    be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_reg [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (be[b]) begin
                    mem_reg[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// EX/MEM pipeline register plus byte/halfword/word loads and stores against
// the internal data RAM.
//   clk   : clock
//   rst_n : synchronous active-low reset of the EX/MEM register
//   stall : hold EX/MEM and hold back the pending store
//   flush : load a bubble into EX/MEM (wins over stall)
//   bus   : *E inputs from Execute, *M results to Writeback / hazard unit
// -----------------------------------------------------------------------------
module memory_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    memory_stage_if.slave bus
);

    localparam int LANES = WIDTH / 8;

    ex_mem_t          ctrl_reg;
    logic [WIDTH-1:0] alu_result_reg;
    logic [WIDTH-1:0] write_data_reg;
    logic [WIDTH-1:0] pc_plus4_reg;

    // A flush clears the data fields too, so a bubble carries no stale address.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ctrl_reg       <= '0;
            alu_result_reg <= '0;
            write_data_reg <= '0;
            pc_plus4_reg   <= '0;
        end else if (!stall) begin
            ctrl_reg.reg_write  <= bus.RegWriteE;
            ctrl_reg.result_src <= bus.ResultSrcE;
            ctrl_reg.mem_write  <= bus.MemWriteE;
            ctrl_reg.funct3     <= bus.Funct3E;
            ctrl_reg.rd         <= bus.RdE;
            alu_result_reg      <= bus.ALUResultE;
            write_data_reg      <= bus.WriteDataE;
            pc_plus4_reg        <= bus.PCPlus4E;
        end
    end

    size_e            size;
    logic             mem_access;
    logic             misalign;
    logic             store_en;
    logic [LANES-1:0] byte_en;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] ram_rdata;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [WIDTH-1:0] load_ext;

    assign size       = access_size(ctrl_reg.funct3);
    assign mem_access = ctrl_reg.mem_write || (ctrl_reg.result_src == RES_MEM);

    // Only a real memory access can be misaligned; ALU ops and bubbles never flag.
    assign misalign = mem_access &&
                      (((size == SZ_HALF) && alu_result_reg[0]) ||
                       ((ctrl_reg.funct3 == F3_W) && (alu_result_reg[1:0] != 2'b00)));

    // rst_n gates the strobe so a store sitting in M at a reset edge is dropped.
    assign store_en = ctrl_reg.mem_write && !stall && rst_n && !misalign;

    // Replicating the store data lets every lane take its bits from the same
    // position; the byte enables then pick which lanes actually change.
    always_comb begin
        store_data = write_data_reg;
        case (size)
            SZ_BYTE: store_data = {LANES{write_data_reg[7:0]}};
            SZ_HALF: store_data = {(LANES/2){write_data_reg[15:0]}};
            default: store_data = write_data_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign byte_en[gi] =
                (size == SZ_WORD) ||
                ((size == SZ_HALF) && (alu_result_reg[1] == 1'((gi / 2) % 2))) ||
                ((size == SZ_BYTE) && (alu_result_reg[1:0] == 2'(gi % 4)));
        end
    endgenerate

    data_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_data_mem (
        .clk   (clk),
        .we    (store_en),
        .be    (byte_en),
        .addr  (alu_result_reg[DEPTH_LOG2+1:2]),
        .wdata (store_data),
        .rdata (ram_rdata)
    );

    assign sel_byte = ram_rdata[{alu_result_reg[1:0], 3'b000} +: 8];
    assign sel_half = ram_rdata[{alu_result_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = ram_rdata;
        case (ctrl_reg.funct3)
            F3_B:    load_ext = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
            F3_H:    load_ext = {{(WIDTH-16){sel_half[15]}}, sel_half};
            F3_BU:   load_ext = {{(WIDTH-8){1'b0}}, sel_byte};
            F3_HU:   load_ext = {{(WIDTH-16){1'b0}}, sel_half};
            default: load_ext = ram_rdata;
        endcase
    end

    // Non-load slots read as 0 so Writeback never sees stray RAM contents.
    assign bus.ReadDataM  = ((ctrl_reg.result_src == RES_MEM) && !misalign) ? load_ext : '0;
    assign bus.MisalignM  = misalign;
    assign bus.RegWriteM  = ctrl_reg.reg_write;
    assign bus.ResultSrcM = ctrl_reg.result_src;
    assign bus.RdM        = ctrl_reg.rd;
    assign bus.ALUResultM = alu_result_reg;
    assign bus.PCPlus4M   = pc_plus4_reg;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory stage of the reduced RISC-V pipeline. It sits directly downstream of Execute and captures Execute's outputs into the EX/MEM pipeline register. It performs byte, halfword and word loads and stores against an internal data RAM. It presents results and forwarding/hazard signals to the Writeback stage and the hazard unit.

Parameters:
WIDTH, 32, datapath width in bits.
DEPTH_LOG2, 10, log2 of the number of data RAM words (1024 x 32-bit by default).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
stall  in  1  hold the EX/MEM register; block store commit
flush  in  1  load a bubble into the EX/MEM register
RegWriteE  in  1  register-write enable from Execute
ResultSrcE  in  2  result select from Execute
MemWriteE  in  1  store enable from Execute
Funct3E  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
ALUResultE  in  WIDTH  byte address or ALU result
WriteDataE  in  WIDTH  store data (rs2)
RdE  in  5  destination register
PCPlus4E  in  WIDTH  link value
RegWriteM  out  1  registered, to Writeback and hazard unit
ResultSrcM  out  2  registered
RdM  out  5  registered
ALUResultM  out  WIDTH  registered; forwarding source
PCPlus4M  out  WIDTH  registered
ReadDataM  out  WIDTH  combinational load result, extended
MisalignM  out  1  combinational; current M access is misaligned

Behaviour:
- Reset: a rising clk edge with rst_n=0 clears every EX/MEM field to 0. After reset, all registered outputs are 0. ReadDataM and MisalignM follow from the cleared state, so both are 0. RAM contents are not reset.
- Register priority per edge: reset > flush > stall > capture.
  - Flush zeroes RegWrite, MemWrite, ResultSrc and Rd. Data fields may also be zeroed.
  - Stall holds every field.
  - Flush and stall together: flush wins.
- Latency: Execute values appear on the M outputs one cycle after capture.
- Load path: combinational. The RAM word index is ALUResultM[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
  - Byte lane is selected by ALUResultM[1:0]; halfword is selected by ALUResultM[1].
  - b/h are sign-extended to WIDTH; bu/hu are zero-extended; w passes through.
  - Undefined Funct3 values read as w.
- Store path: the write commits on the rising clk edge where MemWriteM=1, stall=0, rst_n=1 and MisalignM=0.
  - Byte-lane mask: sb writes WriteDataM[7:0] into the lane at addr[1:0].
  - sh writes WriteDataM[15:0] into the half at addr[1].
  - sw writes the full word.
  - Other lanes are unchanged.
- Misalignment:
  - MisalignM=1 when (h/hu and addr[0]=1) or (w and addr[1:0]!=0). It is meaningful only when MemWriteM=1 or ResultSrcM selects memory.
  - A misaligned store is suppressed. A misaligned load returns 0.
- Store followed by load to the same word in the next instruction: the load sees the new data, because the write lands at the edge and the read is combinational afterwards.
- Stalled store: commits exactly once, on the first edge where stall=0.
- Reset asserted during a pending store: the store is not committed.

Decomposition:
- Shared package pipe_pkg holds:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - ResultSrc encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10.
  - An ex_mem_t struct for the EX/MEM register.
- The stage contains one sub-module, data_mem. It holds the byte-enable write port and the combinational read port, parameterised by DEPTH_LOG2 and WIDTH.
- Lane select, extension and misalignment logic stay in memory_stage.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges, then release. All outputs are 0. With RegWriteE=1, RdE=5 and ALUResultE=0x10 applied, the next edge gives RdM=5, RegWriteM=1, ALUResultM=0x10.
2. sw 0xDEADBEEF @0x40, then lw @0x40: ReadDataM=0xDEADBEEF. Then sb 0x7F @0x41 and lw @0x40: ReadDataM=0xDEAD7FEF. Then lb @0x43: 0xFFFFFFDE. lbu @0x43: 0x000000DE. lh @0x42: 0xFFFFDEAD.
3. sh @0x41 with data 0x1234: MisalignM=1, RAM unchanged (lw @0x40 still 0xDEAD7FEF). lw @0x42: MisalignM=1, ReadDataM=0.
4. sw 0x5 @0x80 held with stall=1 for 3 cycles, data changed in RAM by a backdoor read check: the word is unchanged until the stall=0 edge. It is written exactly once. The M outputs are held throughout.
5. flush=1 and stall=1 together while MemWriteE=1, RegWriteE=1: the next edge gives RegWriteM=0, and no store occurs at the following edge.
6. Address wrap with DEPTH_LOG2=10: sw 0xA5A5A5A5 @0x1000, then lw @0x0 returns 0xA5A5A5A5. Reset asserted during the M cycle of sw @0x20: lw @0x20 afterwards returns the old value.
